// File: rtl/dec_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Full-width decode; callers size-cast the result down to 2^N bits.
   function automatic logic [63:0] decode(input logic [5:0] index, input logic active_low);
      logic [63:0] d;
      d = 64'd1 << index;
      return active_low ? ~d : d;
   endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Dwell timer for scan mode: counts 0..DWELL-1 while run is high, tc flags the last count.
module dec_dwell_cnt
   import dec_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tc
);

   localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [W-1:0] LAST = W'(DWELL - 1);

   logic [W-1:0] cnt_reg;

   assign tc = run && (cnt_reg == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (run) begin
         if (cnt_reg == LAST)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + W'(1);
      end
   end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N decoder with enable, polarity and autonomous scan mode.
// Define DEC_BLANK_EN to insert one inactive cycle between scan positions.
module decoder_scan_seq
   import dec_pkg::*;
#(
   parameter int N          = 2,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic [N-1:0]        sel,
   output logic [(1<<N)-1:0]   out,
   output logic [N-1:0]        idx,
   output logic                wrap
);

   localparam int OUTS = 1 << N;
   localparam logic [OUTS-1:0] INACT   = ACTIVE_LOW ? '1 : '0;
   localparam logic [N-1:0]    IDX_MAX = N'(OUTS - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [OUTS-1:0]   out_reg;
   logic [N-1:0]      idx_reg;
   logic [N-1:0]      idx_inc;
   logic              wrap_reg;
   logic              scan_stay;
   logic              cnt_run;
   logic              cnt_tc;

`ifdef DEC_BLANK_EN
   logic              blank_reg;
`endif

   always_comb begin
      state_next = IDLE;
      if (en)
         state_next = (mode == MODE_SCAN) ? SCAN : DIRECT;
   end

   assign idx_inc   = idx_reg + N'(1);
   assign scan_stay = (state_reg == SCAN) && (state_next == SCAN);

   // The timer is frozen during the blank cycle so each index still shows for DWELL cycles.
`ifdef DEC_BLANK_EN
   assign cnt_run = scan_stay && !blank_reg;
`else
   assign cnt_run = scan_stay;
`endif

   dec_dwell_cnt #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (!scan_stay),
      .run (cnt_run),
      .tc  (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         out_reg   <= INACT;
         idx_reg   <= '0;
         wrap_reg  <= 1'b0;
`ifdef DEC_BLANK_EN
         blank_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         wrap_reg  <= 1'b0;
`ifdef DEC_BLANK_EN
         blank_reg <= 1'b0;
`endif
         case (state_next)
            DIRECT: begin
               idx_reg <= sel;
               out_reg <= OUTS'(decode(6'(sel), ACTIVE_LOW));
            end
            SCAN: begin
               if (state_reg != SCAN) begin
                  idx_reg <= '0;
                  out_reg <= OUTS'(decode(6'd0, ACTIVE_LOW));
               end else begin
`ifdef DEC_BLANK_EN
                  if (blank_reg) begin
                     out_reg <= OUTS'(decode(6'(idx_reg), ACTIVE_LOW));
                  end else if (cnt_tc) begin
                     idx_reg   <= idx_inc;
                     out_reg   <= INACT;
                     blank_reg <= 1'b1;
                     wrap_reg  <= (idx_reg == IDX_MAX);
                  end
`else
                  if (cnt_tc) begin
                     idx_reg  <= idx_inc;
                     out_reg  <= OUTS'(decode(6'(idx_inc), ACTIVE_LOW));
                     wrap_reg <= (idx_reg == IDX_MAX);
                  end
`endif
               end
            end
            default: begin
               idx_reg <= '0;
               out_reg <= INACT;
            end
         endcase
      end
   end

   assign out  = out_reg;
   assign idx  = idx_reg;
   assign wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed self-checking bench for decoder_scan_seq (N=2, DWELL=4 and DWELL=1, both polarities).
module tb_decoder_scan_seq;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic [1:0] sel;
   logic [3:0] out, out_al, out_d1;
   logic [1:0] idx, idx_al, idx_d1;
   logic       wrap, wrap_al, wrap_d1;

   int checks = 0;
   int errors = 0;

`ifdef DEC_BLANK_EN
   localparam int WRAP_C   = 19;
   localparam int SWITCH_C = 10;
`else
   localparam int WRAP_C   = 16;
   localparam int SWITCH_C = 8;
`endif

   decoder_scan_seq #(.N(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .out(out), .idx(idx), .wrap(wrap));

   decoder_scan_seq #(.N(2), .DWELL(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .out(out_al), .idx(idx_al), .wrap(wrap_al));

   decoder_scan_seq #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_d1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .out(out_d1), .idx(idx_d1), .wrap(wrap_d1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0;
      step();
      step();
      checks++; if (out !== 4'b0000) begin errors++; $display("FAIL reset_out got %b want %b", out, 4'b0000); end
      checks++; if (out_al !== 4'b1111) begin errors++; $display("FAIL reset_out_al got %b want %b", out_al, 4'b1111); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
      $display("reset held 2 cycles: out=%b out_al=%b idx=%0d wrap=%b", out, out_al, idx, wrap);
      rst = 1'b0;
      step();
      checks++; if (out !== 4'b0001) begin errors++; $display("FAIL reset_first_scan got %b want %b", out, 4'b0001); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_first_idx got %0d want 0", idx); end
      $display("first scan cycle after reset: out=%b idx=%0d", out, idx);
   endtask

   task automatic test_direct();
      logic [3:0] exp_tab [4];
      exp_tab[0] = 4'b0001; exp_tab[1] = 4'b0010; exp_tab[2] = 4'b0100; exp_tab[3] = 4'b1000;
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         step();
         checks++; if (out !== exp_tab[i]) begin errors++; $display("FAIL direct_out sel=%0d got %b want %b", i, out, exp_tab[i]); end
         checks++; if (out_al !== ~exp_tab[i]) begin errors++; $display("FAIL direct_out_al sel=%0d got %b want %b", i, out_al, ~exp_tab[i]); end
         checks++; if (idx !== 2'(i)) begin errors++; $display("FAIL direct_idx got %0d want %0d", idx, i); end
         checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL direct_wrap got %b want 0", wrap); end
         $display("direct sel=%0d: out=%b out_al=%b idx=%0d", i, out, out_al, idx);
      end
   endtask

   task automatic test_enable_off();
      en = 1'b0; sel = 2'd2; mode = 1'b0;
      step();
      checks++; if (out !== 4'b0000) begin errors++; $display("FAIL enoff_out got %b want %b", out, 4'b0000); end
      checks++; if (out_al !== 4'b1111) begin errors++; $display("FAIL enoff_out_al got %b want %b", out_al, 4'b1111); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL enoff_idx got %0d want 0", idx); end
      $display("enable off: out=%b out_al=%b idx=%0d", out, out_al, idx);
   endtask

   task automatic test_scan_wrap();
      int         ei, ei1;
      logic       eb, eb1, ew, ew1;
      logic [3:0] eo, eo1;
      en = 1'b0; step();
      en = 1'b1; mode = 1'b1;
      step();
      for (int c = 0; c <= WRAP_C; c++) begin
`ifdef DEC_BLANK_EN
         ei  = ((c + 1) / 5) % 4; eb  = (c % 5 == 4); ew  = (c == 19);
         ei1 = ((c + 1) / 2) % 4; eb1 = (c % 2 == 1); ew1 = (c % 8 == 7);
`else
         ei  = (c / 4) % 4;       eb  = 1'b0;         ew  = (c == 16);
         ei1 = c % 4;             eb1 = 1'b0;         ew1 = (c > 0) && (c % 4 == 0);
`endif
         eo  = eb  ? 4'b0000 : (4'b0001 << ei);
         eo1 = eb1 ? 4'b0000 : (4'b0001 << ei1);
         checks++; if (out !== eo) begin errors++; $display("FAIL scan_out c=%0d got %b want %b", c, out, eo); end
         checks++; if (idx !== 2'(ei)) begin errors++; $display("FAIL scan_idx c=%0d got %0d want %0d", c, idx, ei); end
         checks++; if (wrap !== ew) begin errors++; $display("FAIL scan_wrap c=%0d got %b want %b", c, wrap, ew); end
         checks++; if (out_d1 !== eo1) begin errors++; $display("FAIL scan_d1_out c=%0d got %b want %b", c, out_d1, eo1); end
         checks++; if (idx_d1 !== 2'(ei1)) begin errors++; $display("FAIL scan_d1_idx c=%0d got %0d want %0d", c, idx_d1, ei1); end
         checks++; if (wrap_d1 !== ew1) begin errors++; $display("FAIL scan_d1_wrap c=%0d got %b want %b", c, wrap_d1, ew1); end
         $display("scan c=%0d: out=%b idx=%0d wrap=%b | d1 out=%b idx=%0d wrap=%b",
                  c, out, idx, wrap, out_d1, idx_d1, wrap_d1);
         if (c < WRAP_C) step();
      end
   endtask

   task automatic test_mid_switch();
      en = 1'b0; step();
      en = 1'b1; mode = 1'b1;
      step();
      for (int c = 0; c < SWITCH_C; c++) step();
      checks++; if (idx !== 2'd2) begin errors++; $display("FAIL switch_pre_idx got %0d want 2", idx); end
      mode = 1'b0; sel = 2'd3;
      step();
      checks++; if (out !== 4'b1000) begin errors++; $display("FAIL switch_direct_out got %b want %b", out, 4'b1000); end
      checks++; if (idx !== 2'd3) begin errors++; $display("FAIL switch_direct_idx got %0d want 3", idx); end
      $display("mid-scan switch to direct sel=3: out=%b idx=%0d", out, idx);
      mode = 1'b1;
      step();
      checks++; if (out !== 4'b0001) begin errors++; $display("FAIL switch_rescan_out got %b want %b", out, 4'b0001); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL switch_rescan_idx got %0d want 0", idx); end
      step();
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL switch_rescan_hold got %0d want 0", idx); end
      $display("re-enter scan: out=%b idx=%0d", out, idx);
   endtask

   task automatic test_en_fall_scan();
      en = 1'b0; step();
      en = 1'b1; mode = 1'b1;
      step();
      for (int c = 0; c < WRAP_C - 1; c++) step();
      en = 1'b0;
      step();
      checks++; if (out !== 4'b0000) begin errors++; $display("FAIL enfall_out got %b want %b", out, 4'b0000); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL enfall_wrap got %b want 0", wrap); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL enfall_idx got %0d want 0", idx); end
      $display("en dropped just before wrap: out=%b idx=%0d wrap=%b", out, idx, wrap);
   endtask

   task automatic test_back_to_back();
      logic [1:0] seq [6];
      logic [3:0] eo;
      seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd2; seq[3] = 2'd1; seq[4] = 2'd1; seq[5] = 2'd3;
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sel = seq[i];
         step();
         eo = 4'b0001 << seq[i];
         checks++; if (out !== eo) begin errors++; $display("FAIL b2b_out i=%0d got %b want %b", i, out, eo); end
         checks++; if (out_al !== ~eo) begin errors++; $display("FAIL b2b_out_al i=%0d got %b want %b", i, out_al, ~eo); end
         $display("back-to-back sel=%0d: out=%b out_al=%b", seq[i], out, out_al);
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; mode = 1'b0; sel = 2'd3; rst = 1'b1;
      step();
      checks++; if (out !== 4'b0000) begin errors++; $display("FAIL rstmid_out got %b want %b", out, 4'b0000); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL rstmid_idx got %0d want 0", idx); end
      $display("reset mid-operation: out=%b idx=%0d", out, idx);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_enable_off();
      test_scan_wrap();
      test_mid_switch();
      test_en_fall_scan();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
